// File: rtl/alu.sv
// Purpose : packed-lane SIMD adder (4x8, 2x16 or 1x32 lanes), wrap or signed-saturating.
// Latency : 1 cycle, registered output, one result accepted every cycle.
// Backpr. : none; no handshake, the operands are sampled on every rising clk edge.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, clears c
//   a, b     32-bit operands holding packed lanes
//   width    00 = four 8-bit lanes, 01 = two 16-bit lanes, 10/11 = one 32-bit lane
//   saturate 0 = wrap-around add, 1 = signed saturating add
//   c        registered packed lane sums
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  width,
    input  logic        saturate,
    output logic [31:0] c
);

    // Signed overflow happens only when both operands share a sign and the
    // sum's sign differs. An unsigned carry-out on its own is ignored.
    function automatic logic [7:0] add8(input logic [7:0] x,
                                        input logic [7:0] y,
                                        input logic       sat);
        logic [7:0] s;
        logic       ovf;
        s   = x + y;
        ovf = (x[7] == y[7]) && (s[7] != x[7]);
        if (sat && ovf)
            add8 = x[7] ? 8'h80 : 8'h7F;
        else
            add8 = s;
    endfunction

    function automatic logic [15:0] add16(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic        sat);
        logic [15:0] s;
        logic        ovf;
        s   = x + y;
        ovf = (x[15] == y[15]) && (s[15] != x[15]);
        if (sat && ovf)
            add16 = x[15] ? 16'h8000 : 16'h7FFF;
        else
            add16 = s;
    endfunction

    function automatic logic [31:0] add32(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic        sat);
        logic [31:0] s;
        logic        ovf;
        s   = x + y;
        ovf = (x[31] == y[31]) && (s[31] != x[31]);
        if (sat && ovf)
            add32 = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else
            add32 = s;
    endfunction

    // All three lane layouts are computed in parallel and the width selects
    // one. Each lane is its own adder, so carries never cross a lane boundary.
    logic [31:0] sum_8;
    logic [31:0] sum_16;
    logic [31:0] sum_32;
    logic [31:0] sum_sel;

    always_comb begin
        sum_8  = {add8(a[31:24], b[31:24], saturate),
                  add8(a[23:16], b[23:16], saturate),
                  add8(a[15:8],  b[15:8],  saturate),
                  add8(a[7:0],   b[7:0],   saturate)};
        sum_16 = {add16(a[31:16], b[31:16], saturate),
                  add16(a[15:0],  b[15:0],  saturate)};
        sum_32 = add32(a, b, saturate);
    end

    always_comb begin
        sum_sel = sum_32;
        case (width)
            2'b00:   sum_sel = sum_8;
            2'b01:   sum_sel = sum_16;
            default: sum_sel = sum_32;   // 2'b10 and 2'b11 both mean a single 32-bit lane
        endcase
    end

    // The output register is the only state. Reset takes priority over the
    // sum, so any result computed during reset is discarded.
    always_ff @(posedge clk) begin
        if (rst)
            c <= 32'h0000_0000;
        else
            c <= sum_sel;
    end

endmodule

// File: tb/tb_alu.sv
// Purpose : directed self-checking bench for the packed-lane adder alu.
// Latency : each vector is applied, one rising edge passes, then c is sampled 1 time unit later.
// Backpr. : not applicable; the stimulus drives a new vector every cycle.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  width;
    logic        saturate;
    logic [31:0] c;

    int checks = 0;
    int errors = 0;

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .width    (width),
        .saturate (saturate),
        .c        (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one vector, let one rising edge pass, then check c away from the edge.
    task automatic step(input string       tag,
                        input logic        r,
                        input logic [31:0] va,
                        input logic [31:0] vb,
                        input logic [1:0]  w,
                        input logic        s,
                        input logic [31:0] exp);
        rst      = r;
        a        = va;
        b        = vb;
        width    = w;
        saturate = s;
        @(posedge clk);
        #1;
        check(tag, c, exp);
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; width = 2'b00; saturate = 1'b0;
        #2;

        // Reset with arbitrary non-zero operands still present.
        step("reset",          1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 2'b10, 1'b1, 32'h0000_0000);
        step("first_after_rst",1'b0, 32'h0000_0001, 32'h0000_0002, 2'b10, 1'b0, 32'h0000_0003);

        // 32-bit lane.
        step("wrap32",         1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 2'b10, 1'b0, 32'h8000_0000);
        step("sat32_pos",      1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 2'b10, 1'b1, 32'h7FFF_FFFF);
        step("sat32_neg",      1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 1'b1, 32'h8000_0000);
        step("sat32_w3",       1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 2'b11, 1'b1, 32'h7FFF_FFFF);
        step("wrap32_w3",      1'b0, 32'h0000_FFFF, 32'h4000_0001, 2'b11, 1'b0, 32'h4001_0000);
        step("sat32_carry",    1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 1'b1, 32'h0000_0000);

        // 16-bit lanes.
        step("wrap16",         1'b0, 32'h0000_FFFF, 32'h4000_0001, 2'b01, 1'b0, 32'h4000_0000);
        step("sat16_pos",      1'b0, 32'h4000_0001, 32'h0000_7FFF, 2'b01, 1'b1, 32'h4000_7FFF);
        step("sat16_mix",      1'b0, 32'h8000_8000, 32'h8000_0001, 2'b01, 1'b1, 32'h8000_8001);
        step("wrap16_plain",   1'b0, 32'h1234_5678, 32'h1111_1111, 2'b01, 1'b0, 32'h2345_6789);

        // 8-bit lanes.
        step("wrap8",          1'b0, 32'h4000_00FF, 32'h0000_0001, 2'b00, 1'b0, 32'h4000_0000);
        step("sat8_pos",       1'b0, 32'h4000_007F, 32'h0000_0001, 2'b00, 1'b1, 32'h4000_007F);
        step("sat8_neg",       1'b0, 32'h0000_0080, 32'h0000_00FF, 2'b00, 1'b1, 32'h0000_0080);
        step("sat8_carry",     1'b0, 32'h0000_00FF, 32'h0000_0001, 2'b00, 1'b1, 32'h0000_0000);
        step("sat8_lanes",     1'b0, 32'h7F80_FF01, 32'h0180_017F, 2'b00, 1'b1, 32'h7F80_007F);
        step("wrap8_lanes",    1'b0, 32'h7F80_FF01, 32'h0180_017F, 2'b00, 1'b0, 32'h8000_0080);
        step("wrap8_carrychain",1'b0,32'h00FF_FFFF, 32'h0000_0101, 2'b00, 1'b0, 32'h00FF_0000);

        // Back-to-back vectors with mode changes, then a mid-stream reset.
        step("b2b_a",          1'b0, 32'h0001_7FFF, 32'h0000_0001, 2'b01, 1'b1, 32'h0001_7FFF);
        step("b2b_b",          1'b0, 32'h0001_7FFF, 32'h0000_0001, 2'b10, 1'b1, 32'h0001_8000);
        step("mid_reset",      1'b1, 32'h0001_7FFF, 32'h0000_0001, 2'b10, 1'b0, 32'h0000_0000);
        step("after_mid_rst",  1'b0, 32'h0000_0010, 32'h0000_0020, 2'b00, 1'b0, 32'h0000_0030);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
